// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs opcode/register/immediate fields into a word, flags bad immediates,
// and buffers results in a 2-entry FIFO with valid/ready handshakes on both sides (1-cycle latency).
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        err_sticky,
    output logic [15:0] enc_count
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic signed [31:0] w_imm_s;
    logic               w_fits12;
    logic               w_fits13;
    logic               w_fits21;
    logic [31:0]        w_instr;
    logic               w_err;
    logic               w_push;
    logic               w_pop;

    logic [31:0] r_mem_instr [0:1];
    logic        r_mem_err   [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_cnt;
    logic        r_err_sticky;
    logic [15:0] r_enc_count;

    assign w_imm_s  = $signed(in_imm);
    assign w_fits12 = (w_imm_s >= -32'sd2048)    && (w_imm_s <= 32'sd2047);
    assign w_fits13 = (w_imm_s >= -32'sd4096)    && (w_imm_s <= 32'sd4094);
    assign w_fits21 = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574);

    // Out-of-range immediates are still packed truncated; only the error flag marks them.
    always_comb begin
        w_instr = NOP;
        w_err   = 1'b1;
        case (in_opcode)
            OP_R: begin
                w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                w_err   = 1'b0;
            end
            OP_IMM: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
                    w_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    w_err   = (w_imm_s < 32'sd0) || (w_imm_s > 32'sd31);
                end else begin
                    w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    w_err   = ~w_fits12;
                end
            end
            OP_LOAD, OP_JALR: begin
                w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_err   = ~w_fits12;
            end
            OP_STORE: begin
                w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_err   = ~w_fits12;
            end
            OP_BR: begin
                w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
                w_err   = in_imm[0] | ~w_fits13;
            end
            OP_LUI, OP_AUIPC: begin
                w_instr = {in_imm[31:12], in_rd, in_opcode};
                w_err   = (in_imm[11:0] != 12'd0);
            end
            OP_JAL: begin
                w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_err   = in_imm[0] | ~w_fits21;
            end
            default: begin
                w_instr = NOP;
                w_err   = 1'b1;
            end
        endcase
    end

    // Ready depends on occupancy only, so a stalled consumer never reaches back combinationally.
    assign in_ready  = (r_cnt < 2'd2) & ~rst;
    assign out_valid = (r_cnt != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_instr[0] <= 32'd0;
            r_mem_instr[1] <= 32'd0;
            r_mem_err[0]   <= 1'b0;
            r_mem_err[1]   <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_cnt          <= 2'd0;
            r_err_sticky   <= 1'b0;
            r_enc_count    <= 16'd0;
        end else begin
            if (w_push) begin
                r_mem_instr[r_wr_ptr] <= w_instr;
                r_mem_err[r_wr_ptr]   <= w_err;
                r_wr_ptr              <= ~r_wr_ptr;
                if (w_err)
                    r_err_sticky <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= ~r_rd_ptr;
                r_enc_count <= r_enc_count + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign out_instr  = r_mem_instr[r_rd_ptr];
    assign out_err    = r_mem_err[r_rd_ptr];
    assign err_sticky = r_err_sticky;
    assign enc_count  = r_enc_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        err_sticky;
    logic [15:0] enc_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] m_q [$];
    logic        m_sticky;
    logic [15:0] m_count;

    instr_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .err_sticky(err_sticky), .enc_count(enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder: returns {err, word}, built from field positions with shifts/masks.
    function automatic logic [32:0] ref_enc(input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                                            input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                                            input bit [31:0] imm);
        bit [31:0] w, base_i, opv, rdv, f3v, r1v, r2v, f7v;
        bit        e;
        longint    v;
        v = longint'($signed(imm));
        opv = 32'(op); rdv = 32'(rd) << 7; f3v = 32'(f3) << 12;
        r1v = 32'(rs1) << 15; r2v = 32'(rs2) << 20; f7v = 32'(f7) << 25;
        base_i = r1v | f3v | rdv | opv;
        w = 32'h13; e = 1'b1;
        case (op)
            7'h33: begin w = f7v | r2v | r1v | f3v | rdv | opv; e = 1'b0; end
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w = f7v | ((imm & 32'h1F) << 20) | base_i;
                    e = (v < 0) || (v > 31);
                end else begin
                    w = ((imm & 32'hFFF) << 20) | base_i;
                    e = (v < -2048) || (v > 2047);
                end
            end
            7'h23: begin
                w = (((imm >> 5) & 32'h7F) << 25) | r2v | r1v | f3v | ((imm & 32'h1F) << 7) | opv;
                e = (v < -2048) || (v > 2047);
            end
            7'h63: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | r2v | r1v | f3v
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | opv;
                e = (imm[0] == 1'b1) || (v < -4096) || (v > 4094);
            end
            7'h37, 7'h17: begin
                w = (imm & 32'hFFFF_F000) | rdv | opv;
                e = (imm & 32'hFFF) != 0;
            end
            7'h6F: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | rdv | opv;
                e = (imm[0] == 1'b1) || (v < -1048576) || (v > 1048574);
            end
            default: begin w = 32'h13; e = 1'b1; end
        endcase
        return {e, w};
    endfunction

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic cyc(input bit vld, input bit [6:0] op, input bit [2:0] f3, input bit [6:0] f7,
                       input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit [31:0] imm, input bit ordy, input bit chk_en);
        bit          acc, pop;
        logic [32:0] enc;
        in_valid = vld; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; out_ready = ordy;
        enc = ref_enc(op, f3, f7, rd, rs1, rs2, imm);
        @(negedge clk);
        acc = vld && (m_q.size() < 2);
        pop = (m_q.size() != 0) && ordy;
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
            check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("out_instr", out_instr, m_q[0][31:0]);
                check("out_err", 32'(out_err), 32'(m_q[0][32]));
            end
            check("err_sticky", 32'(err_sticky), 32'(m_sticky));
            check("enc_count", 32'(enc_count), 32'(m_count));
        end
        @(posedge clk);
        if (pop) begin
            void'(m_q.pop_front());
            m_count = m_count + 16'd1;
        end
        if (acc) begin
            m_q.push_back(enc);
            if (enc[32]) m_sticky = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, ordy, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_count", 32'(enc_count), 32'd0);
        m_q.delete(); m_sticky = 1'b0; m_count = 16'd0;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    bit [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    bit [31:0] edges [13] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095,
                              -32'sd4096, -32'sd4098, 32'd31, 32'd32, 32'd1048574,
                              -32'sd1048576, 32'd1048576};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        m_sticky = 1'b0; m_count = 16'd0;

        do_reset();
        // addi x1,x0,-1
        cyc(1'b1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("addi_instr", out_instr, 32'hFFF0_0093);
        check("addi_err", 32'(out_err), 32'd0);
        idle(1'b1);
        check("addi_count", 32'(enc_count), 32'd1);
        // beq +8 and jal +16
        cyc(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd8, 1'b1, 1'b1);
        check("beq_instr", out_instr, 32'h0000_0463);
        cyc(1'b1, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 1'b1);
        check("jal_instr", out_instr, 32'h0100_00EF);
        idle(1'b1);
        // error cases and sticky persistence
        cyc(1'b1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 1'b1);
        check("addi2048_instr", out_instr, 32'h8000_0093);
        check("addi2048_err", 32'(out_err), 32'd1);
        check("addi2048_sticky", 32'(err_sticky), 32'd1);
        cyc(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd8, 1'b1, 1'b1);
        check("sticky_holds", 32'(err_sticky), 32'd1);
        check("beq8_err", 32'(out_err), 32'd0);
        cyc(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 1'b1, 1'b1);
        check("beq3_err", 32'(out_err), 32'd1);
        idle(1'b1);

        // backpressure: three requests against a stalled consumer
        do_reset();
        cyc(1'b1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 1'b1);
        cyc(1'b1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 1'b1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        cyc(1'b1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, 1'b1);
        cyc(1'b1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b1, 1'b1);
        cyc(1'b1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b1, 1'b1);
        check("pushpop_occ1_valid", 32'(out_valid), 32'd1);
        check("third_word", out_instr, 32'h0030_0193);
        idle(1'b1);
        check("three_count", 32'(enc_count), 32'd3);
        check("drained", 32'(out_valid), 32'd0);

        // reset with two words buffered
        cyc(1'b1, 7'h33, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0, 1'b1);
        cyc(1'b1, 7'h13, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'd9999, 1'b0, 1'b1);
        do_reset();
        idle(1'b0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit [31:0] imm;
            bit [6:0]  op;
            op = ops[$urandom_range(0, 9)];
            if (op == 7'h00) op = 7'($urandom());
            case ($urandom_range(0, 3))
                0:       imm = 32'($signed($urandom_range(0, 80)) - 40);
                1:       imm = edges[$urandom_range(0, 12)];
                2:       imm = $urandom();
                default: imm = $urandom() & 32'hFFFF_F000;
            endcase
            cyc(1'($urandom_range(0, 3) != 0), op, 3'($urandom()), 7'($urandom()), 5'($urandom()),
                5'($urandom()), 5'($urandom()), imm, 1'($urandom_range(0, 2) != 0), 1'b1);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        // enc_count wrap
        do_reset();
        for (int i = 0; i < 65536; i++)
            cyc(1'b1, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 1'b0);
        check("count_ffff", 32'(enc_count), 32'h0000_FFFF);
        idle(1'b1);
        check("count_wrap", 32'(enc_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
